// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 scan-code sequencer:
//   - Set-2 prefix and keyboard status byte constants
//   - the eight-byte Pause make sequence
//   - the key event record carried through the event FIFO
//   - the sequencer state enumeration
//   - small helpers to classify bytes and build event records
package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;

    // Keyboard status / protocol bytes that never start a key sequence
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // Pause sends E1 14 77 E1 F0 14 F0 77. Entry [0] is the first byte.
    localparam logic [7:0][7:0] PAUSE_SEQ = {
        8'h77, 8'hF0, 8'h14, 8'hF0, 8'hE1, 8'h77, 8'h14, 8'hE1
    };

    // One decoded key event
    typedef struct packed {
        logic       pause;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_E0,
        ST_F0,
        ST_E0F0,
        ST_PAUSE
    } ps2_state_t;

    // True for bytes the keyboard sends about itself rather than about a key
    function automatic logic is_status(input logic [7:0] b);
        return b inside {PS2_BAT_OK, PS2_ACK, PS2_ECHO, PS2_RESEND,
                         PS2_ERR0, PS2_ERR1};
    endfunction

    function automatic ps2_evt_t mk_evt(input logic [7:0] code,
                                        input logic       ext,
                                        input logic       brk,
                                        input logic       pause);
        ps2_evt_t e;
        e.code  = code;
        e.ext   = ext;
        e.brk   = brk;
        e.pause = pause;
        return e;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo
// First-word-fall-through FIFO of ps2_evt_t records built on registered
// storage. The head entry is visible on `head` whenever `empty` is low.
// While empty, `head` keeps showing the last entry that was at the head
// so downstream field outputs do not toggle on idle cycles.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset (empties FIFO, clears flags)
//   push      write request for push_evt
//   push_evt  record to write
//   full      FIFO holds DEPTH entries
//   pop       consumer accepts head; ignored when empty
//   head      head record (last head while empty)
//   empty     FIFO holds no entries
//   overflow  sticky: a push was dropped because the FIFO was full
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  ps2_evt_t push_evt,
    output logic     full,
    input  logic     pop,
    output ps2_evt_t head,
    output logic     empty,
    output logic     overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    ps2_evt_t             mem_q [DEPTH];
    ps2_evt_t             last_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_q;
    logic                 do_push;
    logic                 do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));

    // A pop on a full FIFO frees the slot the simultaneous push lands in
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head     = empty ? last_q : mem_q[rd_ptr_q];
    assign overflow = ovf_q;

    // Control: pointers, occupancy, sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (push && !do_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage: no reset needed, entries are only read while counted valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_evt;
        end
    end

    // Shadow of the head so the outputs read all-zero out of reset and
    // hold steady once the FIFO drains
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
        end else if (!empty) begin
            last_q <= mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/ps2_scancode_sequencer.sv
// ps2_scancode_sequencer
// Turns the raw Set-2 byte stream from a PS/2 byte decoder into single key
// events. E0 (extended) and F0 (break) prefixes are folded into flags on
// the final code byte, the eight-byte E1 Pause sequence becomes one event,
// and keyboard status bytes are filtered out. A stalled multi-byte sequence
// is abandoned after TIMEOUT_CYCLES quiet cycles. Events are queued in a
// small FWFT FIFO read with a valid/ready handshake.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   code_i        scan-code byte from the decoder
//   code_valid_i  one-cycle strobe qualifying code_i
//   evt_valid_o   an event is at the FIFO head
//   evt_ready_i   consumer takes the head event (pop on valid && ready)
//   evt_code_o    key code of the head event (00 for Pause)
//   evt_ext_o     head event had an E0 prefix
//   evt_break_o   head event had an F0 prefix (key release)
//   evt_pause_o   head event is the Pause key
//   overflow_o    sticky: an event was dropped on a full FIFO
//   timeout_o     one-cycle pulse: a partial sequence was abandoned
//   busy_o        a multi-byte sequence is in progress
module ps2_scancode_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_i,
    input  logic       code_valid_i,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [7:0] evt_code_o,
    output logic       evt_ext_o,
    output logic       evt_break_o,
    output logic       evt_pause_o,
    output logic       overflow_o,
    output logic       timeout_o,
    output logic       busy_o
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    ps2_state_t       state_q;
    ps2_state_t       state_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic [TMR_W-1:0] tmr_q;
    logic             timeout_q;
    logic             busy_q;
    logic             expire;
    logic             push;
    ps2_evt_t         push_evt;
    ps2_evt_t         head;
    logic             fifo_empty;
    logic             fifo_full_unused;

    // A byte arriving in the expiry cycle wins over the timeout
    assign expire = (state_q != ST_IDLE) && !code_valid_i &&
                    (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // The event is pushed in the same cycle as its final byte so that it
    // reaches the FIFO head on the following cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        push     = 1'b0;
        push_evt = '0;
        if (code_valid_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (code_i == PS2_EXT) begin
                        state_d = ST_E0;
                    end else if (code_i == PS2_BRK) begin
                        state_d = ST_F0;
                    end else if (code_i == PS2_PAUSE) begin
                        state_d = ST_PAUSE;
                        idx_d   = 3'd1;
                    end else if (!is_status(code_i)) begin
                        push     = 1'b1;
                        push_evt = mk_evt(code_i, 1'b0, 1'b0, 1'b0);
                    end
                end
                ST_E0: begin
                    if (code_i == PS2_BRK) begin
                        state_d = ST_E0F0;
                    end else if (code_i != PS2_EXT) begin
                        push     = 1'b1;
                        push_evt = mk_evt(code_i, 1'b1, 1'b0, 1'b0);
                        state_d  = ST_IDLE;
                    end
                end
                ST_F0: begin
                    push     = 1'b1;
                    push_evt = mk_evt(code_i, 1'b0, 1'b1, 1'b0);
                    state_d  = ST_IDLE;
                end
                ST_E0F0: begin
                    push     = 1'b1;
                    push_evt = mk_evt(code_i, 1'b1, 1'b1, 1'b0);
                    state_d  = ST_IDLE;
                end
                ST_PAUSE: begin
                    // Any deviation from the fixed sequence drops the
                    // whole thing, including the offending byte.
                    if (code_i == PAUSE_SEQ[idx_q]) begin
                        if (idx_q == 3'd7) begin
                            push     = 1'b1;
                            push_evt = mk_evt(8'h00, 1'b0, 1'b0, 1'b1);
                            state_d  = ST_IDLE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (expire) begin
            state_d = ST_IDLE;
        end
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tmr_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timeout_q <= expire;
            busy_q    <= (state_d != ST_IDLE);
            if (code_valid_i || (state_q == ST_IDLE) || expire) begin
                tmr_q <= '0;
            end else begin
                tmr_q <= tmr_q + TMR_W'(1);
            end
        end
    end

    // The FIFO drops and flags pushes on its own, so its full flag is
    // not needed here.
    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_evt (push_evt),
        .full     (fifo_full_unused),
        .pop      (evt_ready_i),
        .head     (head),
        .empty    (fifo_empty),
        .overflow (overflow_o)
    );

    assign evt_valid_o = !fifo_empty;
    assign evt_code_o  = head.code;
    assign evt_ext_o   = head.ext;
    assign evt_break_o = head.brk;
    assign evt_pause_o = head.pause;
    assign timeout_o   = timeout_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// tb_ps2_scancode_sequencer
// Directed stimulus against a byte-sequence model of the sequencer. The
// model keeps the bytes of the sequence in progress and decides from the
// whole sequence what event (if any) it forms; events go into a bounded
// queue standing in for the FIFO. A negedge process compares every output
// with the model each cycle; literal checks pin key moments.
module tb_ps2_scancode_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] code_i = 8'h00;
    logic       code_valid_i = 1'b0;
    logic       evt_ready_i = 1'b0;
    logic       evt_valid_o;
    logic [7:0] evt_code_o;
    logic       evt_ext_o;
    logic       evt_break_o;
    logic       evt_pause_o;
    logic       overflow_o;
    logic       timeout_o;
    logic       busy_o;

    ps2_scancode_sequencer #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .code_i       (code_i),
        .code_valid_i (code_valid_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_code_o   (evt_code_o),
        .evt_ext_o    (evt_ext_o),
        .evt_break_o  (evt_break_o),
        .evt_pause_o  (evt_pause_o),
        .overflow_o   (overflow_o),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        bit         ext;
        bit         brk;
        bit         pause;
    } mev_t;

    mev_t       mq[$];
    logic [7:0] sbuf[$];
    bit         m_ovf = 0;
    bit         m_tmo = 0;
    int         edge_n = 0;
    int         last_edge = 0;
    bit         chk_en = 0;
    bit         rdy = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] pause_ref [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                                  8'hF0, 8'h14, 8'hF0, 8'h77};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_stat(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    // Decide what the byte does given the bytes already collected
    task automatic model_byte(input logic [7:0] b, output bit has, output mev_t e);
        bit seen_e0;
        bit seen_f0;
        has = 0;
        e   = '{8'h00, 0, 0, 0};
        if (sbuf.size() == 0) begin
            if (is_stat(b)) return;
            if (b == 8'hE1) begin
                sbuf.push_back(b);
                return;
            end
        end
        if (sbuf.size() > 0 && sbuf[0] == 8'hE1) begin
            if (b == pause_ref[sbuf.size()]) begin
                sbuf.push_back(b);
                if (sbuf.size() == 8) begin
                    has = 1;
                    e   = '{8'h00, 0, 0, 1};
                    sbuf.delete();
                end
            end else begin
                sbuf.delete();
            end
            return;
        end
        seen_e0 = 0;
        seen_f0 = 0;
        foreach (sbuf[i]) begin
            if (sbuf[i] == 8'hE0) seen_e0 = 1;
            if (sbuf[i] == 8'hF0) seen_f0 = 1;
        end
        if (!seen_f0 && (b == 8'hE0 || b == 8'hF0)) begin
            sbuf.push_back(b);
            return;
        end
        has = 1;
        e   = '{b, seen_e0, seen_f0, 0};
        sbuf.delete();
    endtask

    task automatic model_edge(input bit v, input logic [7:0] b, input bit r);
        bit   has;
        mev_t e;
        bit   do_pop;
        edge_n++;
        m_tmo  = 0;
        has    = 0;
        do_pop = r && (mq.size() > 0);
        if (v) begin
            model_byte(b, has, e);
            last_edge = edge_n;
        end else if (sbuf.size() > 0 && (edge_n - last_edge) == TMO) begin
            sbuf.delete();
            m_tmo = 1;
        end
        if (do_pop) void'(mq.pop_front());
        if (has) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1;
        end
    endtask

    task automatic step(input bit v, input logic [7:0] b);
        code_valid_i = v;
        code_i       = b;
        evt_ready_i  = rdy;
        @(posedge clk);
        model_edge(v, b, rdy);
        #1;
        code_valid_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        step(1, b);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        code_valid_i = 1'b0;
        @(posedge clk);
        mq.delete();
        sbuf.delete();
        m_ovf  = 0;
        m_tmo  = 0;
        edge_n++;
        #1;
        rst    = 1'b0;
        chk_en = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("evt_valid", evt_valid_o, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("evt_code",  evt_code_o,  mq[0].code);
                chk("evt_ext",   evt_ext_o,   mq[0].ext);
                chk("evt_break", evt_break_o, mq[0].brk);
                chk("evt_pause", evt_pause_o, mq[0].pause);
            end
            chk("overflow", overflow_o, m_ovf);
            chk("timeout",  timeout_o,  m_tmo);
            chk("busy",     busy_o,     sbuf.size() != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state: every output low
        do_reset();
        chk("rst_valid", evt_valid_o, 1'b0);
        chk("rst_code",  evt_code_o,  8'h00);
        chk("rst_flags", {evt_ext_o, evt_break_o, evt_pause_o, overflow_o,
                          timeout_o, busy_o}, 6'b0);

        // A make, then A break
        rdy = 0;
        send(8'h1C);
        chk("a_make_valid", evt_valid_o, 1'b1);
        chk("a_make_code",  evt_code_o,  8'h1C);
        chk("a_make_brk",   evt_break_o, 1'b0);
        rdy = 1;
        gap(2);
        send(8'hF0);
        send(8'h1C);
        chk("a_break", {evt_valid_o, evt_code_o, evt_ext_o, evt_break_o},
            {1'b1, 8'h1C, 1'b0, 1'b1});
        gap(3);

        // Up make/break with status bytes in between
        send(8'hE0); send(8'h75);
        chk("up_make", {evt_valid_o, evt_code_o, evt_ext_o, evt_break_o},
            {1'b1, 8'h75, 1'b1, 1'b0});
        send(8'hAA); send(8'hFA);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("up_break", {evt_valid_o, evt_code_o, evt_ext_o, evt_break_o},
            {1'b1, 8'h75, 1'b1, 1'b1});
        send(8'hE0); send(8'hE0); send(8'h6B);
        gap(3);

        // Full Pause, then a corrupted one
        rdy = 0;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("pause_evt", {evt_valid_o, evt_code_o, evt_pause_o, busy_o},
            {1'b1, 8'h00, 1'b1, 1'b0});
        rdy = 1;
        gap(2);
        send(8'hE1); send(8'h14);
        chk("pause_busy", busy_o, 1'b1);
        send(8'h76);
        chk("pause_abort_busy", busy_o, 1'b0);
        gap(2);
        chk("pause_abort_noevt", evt_valid_o, 1'b0);

        // Fill, overflow, push+pop on full, drain
        rdy = 0;
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        chk("full_no_ovf", overflow_o, 1'b0);
        send(8'h2E);
        chk("ovf_set", overflow_o, 1'b1);
        chk("ovf_head", evt_code_o, 8'h16);
        rdy = 1;
        send(8'h36);
        chk("full_pushpop_head", evt_code_o, 8'h1E);
        gap(6);

        // Timeout after E0, then a plain key
        send(8'hE0);
        gap(TMO - 1);
        chk("tmo_before", {timeout_o, busy_o}, 2'b01);
        gap(1);
        chk("tmo_pulse", {timeout_o, busy_o, evt_valid_o}, 3'b100);
        gap(1);
        chk("tmo_once", timeout_o, 1'b0);
        send(8'h1C);
        chk("post_tmo", {evt_valid_o, evt_code_o, evt_ext_o}, {1'b1, 8'h1C, 1'b0});
        gap(2);

        // Byte in the expiry cycle wins
        send(8'hE0);
        gap(TMO - 1);
        send(8'h74);
        chk("tmo_prio", {timeout_o, evt_valid_o, evt_code_o, evt_ext_o},
            {1'b0, 1'b1, 8'h74, 1'b1});
        gap(TMO + 2);

        // Reset mid-sequence with events queued
        rdy = 0;
        send(8'h1C); send(8'h32);
        send(8'hE0); send(8'hF0);
        do_reset();
        chk("midrst", {evt_valid_o, overflow_o, busy_o}, 3'b000);
        rdy = 1;
        send(8'h29);
        chk("after_rst", {evt_valid_o, evt_code_o, evt_ext_o, evt_break_o},
            {1'b1, 8'h29, 1'b0, 1'b0});
        gap(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
